// File: rtl/aes_key_sched.sv
// aes_key_sched: on-the-fly AES key expansion for AES-128/192/256 (NK = 4/6/8).
//
// Key words are loaded most-significant first and streamed through unchanged as
// w[0..NK-1]. The remaining words, up to w[4*Nr+3], are then generated at one
// word per cycle over a valid/ready handshake. SubWord goes through an external
// combinational S-box (sbox_in -> sbox_out), so this block holds no tables.
//
// Optional feature macro: KEY_SCHED_FINAL_KEY_EN adds final_key/final_key_valid,
// which hold the last NK-word window once expansion completes.
//
// Ports:
//   clk, reset_n        clock, asynchronous active-low reset
//   start               pulse; begins (or restarts) a key load
//   key_valid, key_in   cipher key word input
//   rk_valid, rk_ready  round-key output handshake
//   rk_word, rk_rnd     expanded word w[i] and its round index i/4
//   rk_last             marks w[4*Nr+3]
//   busy                high while loading or generating
//   sbox_in, sbox_out   shared S-box request/response
//   final_key(_valid)   last NK words (only with KEY_SCHED_FINAL_KEY_EN)
module aes_key_sched #(
  parameter int unsigned NK = 8
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               start,
  input  logic               key_valid,
  input  logic [31:0]        key_in,
  output logic               rk_valid,
  input  logic               rk_ready,
  output logic [31:0]        rk_word,
  output logic [3:0]         rk_rnd,
  output logic               rk_last,
  output logic               busy,
  output logic [31:0]        sbox_in,
  input  logic [31:0]        sbox_out
`ifdef KEY_SCHED_FINAL_KEY_EN
  ,
  output logic [32*NK-1:0]   final_key,
  output logic               final_key_valid
`endif
);

  localparam int unsigned NR    = NK + 6;
  localparam int unsigned TOTAL = 4 * NR + 4;

  if (NK != 4 && NK != 6 && NK != 8) begin : g_bad_nk
    $error("aes_key_sched: NK must be 4, 6 or 8");
  end

  typedef enum logic [1:0] {StIdle, StLoad, StGen, StDone} state_e;

  state_e      state_q, state_d;
  logic [31:0] window_q [NK];
  logic [5:0]  cnt_q, cnt_d;       // index i of the next word to produce
  logic [2:0]  mod_q, mod_d;       // i mod NK, valid while generating
  logic [7:0]  rcon_q, rcon_d;
  logic        rk_valid_q, rk_valid_d;
  logic [31:0] rk_word_q, rk_word_d;
  logic [3:0]  rk_rnd_q, rk_rnd_d;
  logic        rk_last_q, rk_last_d;

  logic        shift_en;
  logic [31:0] shift_word;
  logic [31:0] last_w, temp, w_new;
  logic        gen_done, out_adv, at_rcon, at_sub;

  assign last_w   = window_q[NK-1];
  assign at_rcon  = (mod_q == 3'd0);
  assign at_sub   = (NK == 8) && (mod_q == 3'd4);
  assign gen_done = (cnt_q == 6'(TOTAL));
  assign out_adv  = !rk_valid_q || rk_ready;

  // sbox_out is SubWord of whatever sbox_in presents, so it already includes RotWord.
  always_comb begin
    if (at_rcon) begin
      temp = sbox_out ^ {rcon_q, 24'h0};
    end else if (at_sub) begin
      temp = sbox_out;
    end else begin
      temp = last_w;
    end
    w_new = window_q[0] ^ temp;
  end

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    if (start) begin
      state_d = StLoad;
    end else begin
      unique case (state_q)
        StLoad:  if (key_valid && cnt_q == 6'(NK - 1)) state_d = StGen;
        StGen:   if (gen_done && rk_valid_q && rk_ready) state_d = StDone;
        default: ;
      endcase
    end
  end

  // Outputs decoded from state and window.
  always_comb begin
    busy    = (state_q == StLoad) || (state_q == StGen);
    sbox_in = at_rcon ? {last_w[23:0], last_w[31:24]} : last_w;
  end

  // Datapath next-state.
  always_comb begin
    cnt_d      = cnt_q;
    mod_d      = mod_q;
    rcon_d     = rcon_q;
    rk_valid_d = rk_valid_q;
    rk_word_d  = rk_word_q;
    rk_rnd_d   = rk_rnd_q;
    rk_last_d  = rk_last_q;
    shift_en   = 1'b0;
    shift_word = key_in;
    if (start) begin
      cnt_d      = '0;
      mod_d      = '0;
      rcon_d     = 8'h01;
      rk_valid_d = 1'b0;
      rk_last_d  = 1'b0;
    end else begin
      unique case (state_q)
        StLoad: begin
          if (key_valid) begin
            shift_en   = 1'b1;
            rk_word_d  = key_in;
            rk_valid_d = 1'b1;
            rk_rnd_d   = cnt_q[5:2];
            rk_last_d  = 1'b0;
            cnt_d      = cnt_q + 6'd1;
          end else if (rk_ready) begin
            rk_valid_d = 1'b0;
          end
        end
        StGen: begin
          if (gen_done) begin
            if (rk_valid_q && rk_ready) begin
              rk_valid_d = 1'b0;
              rk_last_d  = 1'b0;
            end
          end else if (out_adv) begin
            shift_en   = 1'b1;
            shift_word = w_new;
            rk_word_d  = w_new;
            rk_valid_d = 1'b1;
            rk_rnd_d   = cnt_q[5:2];
            rk_last_d  = (cnt_q == 6'(TOTAL - 1));
            cnt_d      = cnt_q + 6'd1;
            mod_d      = (mod_q == 3'(NK - 1)) ? 3'd0 : mod_q + 3'd1;
            if (at_rcon) begin
              rcon_d = {rcon_q[6:0], 1'b0} ^ (rcon_q[7] ? 8'h1b : 8'h00);
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q      <= '0;
      mod_q      <= '0;
      rcon_q     <= 8'h01;
      rk_valid_q <= 1'b0;
      rk_word_q  <= '0;
      rk_rnd_q   <= '0;
      rk_last_q  <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      mod_q      <= mod_d;
      rcon_q     <= rcon_d;
      rk_valid_q <= rk_valid_d;
      rk_word_q  <= rk_word_d;
      rk_rnd_q   <= rk_rnd_d;
      rk_last_q  <= rk_last_d;
    end
  end

  // window_q[0] holds w[i-NK], window_q[NK-1] holds w[i-1].
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned j = 0; j < NK; j++) window_q[j] <= '0;
    end else if (shift_en) begin
      for (int unsigned j = 0; j < NK - 1; j++) window_q[j] <= window_q[j+1];
      window_q[NK-1] <= shift_word;
    end
  end

  assign rk_valid = rk_valid_q;
  assign rk_word  = rk_word_q;
  assign rk_rnd   = rk_rnd_q;
  assign rk_last  = rk_last_q;

`ifdef KEY_SCHED_FINAL_KEY_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      final_key       <= '0;
      final_key_valid <= 1'b0;
    end else if (start) begin
      final_key       <= '0;
      final_key_valid <= 1'b0;
    end else if (state_q == StGen && state_d == StDone) begin
      // Newest word (w[4*Nr+3]) lands in the LSBs.
      for (int unsigned j = 0; j < NK; j++) final_key[32*(NK-1-j) +: 32] <= window_q[j];
      final_key_valid <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_aes_key_sched.sv
// Testbench for aes_key_sched: one instance each of NK = 4, 6, 8, driven against
// a FIPS-197-style key-expansion model with an arithmetic S-box.
module tb_aes_key_sched;

  typedef logic [31:0] key_t [8];

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                reset_n;
  logic [2:0]          start_v, key_valid_v, rk_ready_v;
  logic [2:0][31:0]    key_in_p;
  logic [2:0]          rk_valid_v, rk_last_v, busy_v;
  logic [2:0][31:0]    rk_word_p, sbox_in_p;
  logic [2:0][3:0]     rk_rnd_p;
`ifdef KEY_SCHED_FINAL_KEY_EN
  logic [2:0]          fk_valid_v;
  logic [2:0][31:0]    fk_lsw_p;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  // GF(2^8) arithmetic for the reference S-box.
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] aa = a;
    logic [7:0] bb = b;
    for (int k = 0; k < 8; k++) begin
      if (bb[0]) p = p ^ aa;
      aa = aa[7] ? ({aa[6:0], 1'b0} ^ 8'h1b) : {aa[6:0], 1'b0};
      bb = bb >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] sbox_byte(input logic [7:0] x);
    logic [7:0] r = 8'h01;
    logic [7:0] e = 8'd254;
    logic [7:0] b;
    for (int k = 7; k >= 0; k--) begin
      r = gmul(r, r);
      if (e[k]) r = gmul(r, x);
    end
    b = (x == 8'h00) ? 8'h00 : r;
    return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox_byte(w[31:24]), sbox_byte(w[23:16]), sbox_byte(w[15:8]), sbox_byte(w[7:0])};
  endfunction

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int unsigned NKG = (g == 0) ? 4 : (g == 1) ? 6 : 8;
    logic [31:0] sb_in, sb_out;
    assign sb_out       = sub_word(sb_in);
    assign sbox_in_p[g] = sb_in;
`ifdef KEY_SCHED_FINAL_KEY_EN
    logic [32*NKG-1:0] fk;
    logic              fkv;
    assign fk_lsw_p[g]   = fk[31:0];
    assign fk_valid_v[g] = fkv;
`endif
    aes_key_sched #(.NK(NKG)) u_dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .start     (start_v[g]),
      .key_valid (key_valid_v[g]),
      .key_in    (key_in_p[g]),
      .rk_valid  (rk_valid_v[g]),
      .rk_ready  (rk_ready_v[g]),
      .rk_word   (rk_word_p[g]),
      .rk_rnd    (rk_rnd_p[g]),
      .rk_last   (rk_last_v[g]),
      .busy      (busy_v[g]),
      .sbox_in   (sb_in),
      .sbox_out  (sb_out)
`ifdef KEY_SCHED_FINAL_KEY_EN
      ,
      .final_key       (fk),
      .final_key_valid (fkv)
`endif
    );
  end

  // Reference expansion straight from the key-schedule definition.
  logic [31:0] exp_w [64];

  task automatic model_expand(input int nk, input key_t key);
    logic [31:0] t;
    logic [7:0]  rc;
    for (int i = 0; i < 4 * nk + 28; i++) begin
      if (i < nk) begin
        exp_w[i] = key[i];
      end else begin
        t = exp_w[i-1];
        if (i % nk == 0) begin
          rc = 8'h01;
          for (int k = 1; k < i / nk; k++) rc = gmul(rc, 8'h02);
          t = sub_word({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        end else if (nk == 8 && i % nk == 4) begin
          t = sub_word(t);
        end
        exp_w[i] = exp_w[i-nk] ^ t;
      end
    end
  endtask

  // Results of the most recent run.
  logic [31:0] got_w [64];
  logic [3:0]  got_r [64];
  logic        got_l [64];
  int          n_got, stab_err;
  logic        timed_out, post_start_valid, post_done_valid, post_done_busy, saw_busy;

  // Starts a load on DUT d, feeds the key and collects accepted words. Stops after
  // the last word, after stop_after words (if nonzero), or after a cycle budget.
  task automatic drive_run(input int d, input int nk, input key_t key,
                           input int unsigned ready_pct, input int stop_after);
    logic        done = 1'b0;
    logic        stall = 1'b0;
    logic [31:0] pw = '0;
    logic [3:0]  pr = '0;
    logic        pl = 1'b0;
    for (int i = 0; i < 64; i++) begin
      got_w[i] = 'x;
      got_r[i] = 'x;
      got_l[i] = 1'bx;
    end
    n_got = 0; stab_err = 0; saw_busy = 1'b0;
    @(negedge clk);
    start_v[d] = 1'b1; key_valid_v[d] = 1'b0; rk_ready_v[d] = 1'b1;
    @(negedge clk);
    start_v[d] = 1'b0;
    post_start_valid = rk_valid_v[d];
    for (int cyc = 0; cyc < 400; cyc++) begin
      if (cyc < nk) begin
        key_valid_v[d] = 1'b1; key_in_p[d] = key[cyc]; rk_ready_v[d] = 1'b1;
      end else begin
        key_valid_v[d] = 1'b0; key_in_p[d] = $urandom;
        rk_ready_v[d] = ($urandom_range(99) < ready_pct);
      end
      if (busy_v[d]) saw_busy = 1'b1;
      if (stall && (!rk_valid_v[d] || rk_word_p[d] !== pw || rk_rnd_p[d] !== pr ||
                    rk_last_v[d] !== pl)) stab_err++;
      stall = rk_valid_v[d] && !rk_ready_v[d];
      pw = rk_word_p[d]; pr = rk_rnd_p[d]; pl = rk_last_v[d];
      if (rk_valid_v[d] && rk_ready_v[d]) begin
        if (n_got < 64) begin
          got_w[n_got] = rk_word_p[d]; got_r[n_got] = rk_rnd_p[d]; got_l[n_got] = rk_last_v[d];
        end
        n_got++;
        if (rk_last_v[d]) done = 1'b1;
      end
      @(negedge clk);
      if (done || (stop_after > 0 && n_got >= stop_after)) break;
    end
    key_valid_v[d] = 1'b0;
    timed_out = !done && !(stop_after > 0 && n_got >= stop_after);
    post_done_valid = rk_valid_v[d];
    post_done_busy  = busy_v[d];
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    start_v = '0; key_valid_v = '0; rk_ready_v = '0; key_in_p = '0;
    repeat (3) @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      n_tests++;
      if ({rk_valid_v[d], rk_word_p[d], rk_rnd_p[d], rk_last_v[d], busy_v[d], sbox_in_p[d]}
          !== 71'h0) begin
        n_fail++;
        $display("FAIL reset_state dut%0d: valid=%b word=%h rnd=%0d last=%b busy=%b sbox_in=%h want all 0",
                 d, rk_valid_v[d], rk_word_p[d], rk_rnd_p[d], rk_last_v[d], busy_v[d],
                 sbox_in_p[d]);
      end
    end
    reset_n = 1'b1;
  endtask

  task automatic test_known_answer(input int d, input int nk, input key_t key,
                                   input int ia, input logic [31:0] va,
                                   input int ib, input logic [31:0] vb,
                                   input logic [31:0] vlast);
    int total = 4 * nk + 28;
    model_expand(nk, key);
    drive_run(d, nk, key, 100, 0);
    n_tests++;
    if (timed_out) begin n_fail++; $display("FAIL kat%0d_timeout: got %0d words", nk, n_got); end
    n_tests++;
    if (n_got != total) begin
      n_fail++; $display("FAIL kat%0d_count: got %0d want %0d", nk, n_got, total);
    end
    for (int i = 0; i < total; i++) begin
      n_tests++;
      if (got_w[i] !== exp_w[i] || got_r[i] !== 4'(i / 4) || got_l[i] !== (i == total - 1)) begin
        n_fail++;
        $display("FAIL kat%0d_w%0d: got %h rnd %0d last %b want %h rnd %0d last %b", nk, i,
                 got_w[i], got_r[i], got_l[i], exp_w[i], i / 4, i == total - 1);
      end
    end
    n_tests++;
    if (got_w[ia] !== va) begin n_fail++; $display("FAIL kat%0d_vec_a: got %h want %h", nk, got_w[ia], va); end
    n_tests++;
    if (got_w[ib] !== vb) begin n_fail++; $display("FAIL kat%0d_vec_b: got %h want %h", nk, got_w[ib], vb); end
    n_tests++;
    if (got_w[total-1] !== vlast || got_r[total-1] !== 4'(nk + 6)) begin
      n_fail++;
      $display("FAIL kat%0d_final: got %h rnd %0d want %h rnd %0d", nk, got_w[total-1],
               got_r[total-1], vlast, nk + 6);
    end
    n_tests++;
    if (post_done_valid !== 1'b0 || post_done_busy !== 1'b0 || saw_busy !== 1'b1) begin
      n_fail++;
      $display("FAIL kat%0d_done: valid=%b busy=%b saw_busy=%b want 0 0 1", nk, post_done_valid,
               post_done_busy, saw_busy);
    end
`ifdef KEY_SCHED_FINAL_KEY_EN
    n_tests++;
    if (fk_valid_v[d] !== 1'b1 || fk_lsw_p[d] !== vlast) begin
      n_fail++;
      $display("FAIL kat%0d_final_key: valid=%b lsw=%h want 1 %h", nk, fk_valid_v[d], fk_lsw_p[d], vlast);
    end
`endif
  endtask

  task automatic test_backpressure(input key_t key);
    model_expand(8, key);
    drive_run(2, 8, key, 45, 0);
    n_tests++;
    if (n_got != 60 || timed_out) begin
      n_fail++; $display("FAIL bp_count: got %0d timeout %b want 60 0", n_got, timed_out);
    end
    n_tests++;
    if (stab_err != 0) begin n_fail++; $display("FAIL bp_stable: got %0d unstable cycles want 0", stab_err); end
    for (int i = 0; i < 60; i++) begin
      n_tests++;
      if (got_w[i] !== exp_w[i]) begin
        n_fail++; $display("FAIL bp_w%0d: got %h want %h", i, got_w[i], exp_w[i]);
      end
    end
  endtask

  task automatic test_random_keys();
    key_t key;
    for (int rep = 0; rep < 2; rep++) begin
      for (int d = 0; d < 3; d++) begin
        int nk = 4 + 2 * d;
        for (int k = 0; k < 8; k++) key[k] = $urandom;
        model_expand(nk, key);
        drive_run(d, nk, key, 70, 0);
        n_tests++;
        if (n_got != 4 * nk + 28 || timed_out || stab_err != 0) begin
          n_fail++;
          $display("FAIL rand_nk%0d_run: got %0d words timeout %b unstable %0d want %0d 0 0", nk,
                   n_got, timed_out, stab_err, 4 * nk + 28);
        end
        for (int i = 0; i < 4 * nk + 28; i++) begin
          n_tests++;
          if (got_w[i] !== exp_w[i] || got_r[i] !== 4'(i / 4)) begin
            n_fail++;
            $display("FAIL rand_nk%0d_w%0d: got %h rnd %0d want %h rnd %0d", nk, i, got_w[i],
                     got_r[i], exp_w[i], i / 4);
          end
        end
      end
    end
  endtask

  task automatic test_abort_restart(input key_t key);
    model_expand(8, key);
    drive_run(2, 8, key, 100, 20);
    drive_run(2, 8, key, 100, 0);
    n_tests++;
    if (post_start_valid !== 1'b0) begin
      n_fail++; $display("FAIL abort_valid_drop: got %b want 0", post_start_valid);
    end
    n_tests++;
    if (got_w[0] !== 32'h603deb10 || n_got != 60) begin
      n_fail++; $display("FAIL abort_first: got %h count %0d want 603deb10 60", got_w[0], n_got);
    end
    for (int i = 0; i < 60; i++) begin
      n_tests++;
      if (got_w[i] !== exp_w[i]) begin
        n_fail++; $display("FAIL abort_w%0d: got %h want %h", i, got_w[i], exp_w[i]);
      end
    end
  endtask

  task automatic test_reset_mid_run(input key_t key);
    model_expand(8, key);
    drive_run(2, 8, key, 80, 30);
    reset_n = 1'b0;
    #1;
    n_tests++;
    if ({rk_valid_v[2], rk_word_p[2], rk_rnd_p[2], rk_last_v[2], busy_v[2], sbox_in_p[2]} !== 71'h0) begin
      n_fail++;
      $display("FAIL midreset_outputs: valid=%b word=%h rnd=%0d last=%b busy=%b sbox_in=%h want all 0",
               rk_valid_v[2], rk_word_p[2], rk_rnd_p[2], rk_last_v[2], busy_v[2], sbox_in_p[2]);
    end
`ifdef KEY_SCHED_FINAL_KEY_EN
    n_tests++;
    if (fk_valid_v[2] !== 1'b0 || fk_lsw_p[2] !== 32'h0) begin
      n_fail++; $display("FAIL midreset_final_key: valid=%b lsw=%h want 0 0", fk_valid_v[2], fk_lsw_p[2]);
    end
`endif
    @(negedge clk);
    n_tests++;
    if (rk_valid_v[2] !== 1'b0 || busy_v[2] !== 1'b0) begin
      n_fail++; $display("FAIL midreset_hold: valid=%b busy=%b want 0 0", rk_valid_v[2], busy_v[2]);
    end
    reset_n = 1'b1;
    drive_run(2, 8, key, 80, 0);
    n_tests++;
    if (n_got != 60 || timed_out) begin
      n_fail++; $display("FAIL midreset_count: got %0d timeout %b want 60 0", n_got, timed_out);
    end
    for (int i = 0; i < 60; i++) begin
      n_tests++;
      if (got_w[i] !== exp_w[i]) begin
        n_fail++; $display("FAIL midreset_w%0d: got %h want %h", i, got_w[i], exp_w[i]);
      end
    end
`ifdef KEY_SCHED_FINAL_KEY_EN
    n_tests++;
    if (fk_valid_v[2] !== 1'b1 || fk_lsw_p[2] !== 32'h706c631e) begin
      n_fail++; $display("FAIL midreset_final_key_after: valid=%b lsw=%h want 1 706c631e",
                         fk_valid_v[2], fk_lsw_p[2]);
    end
`endif
  endtask

  initial begin
    key_t k256, k128, k192;
    k256 = '{32'h603deb10, 32'h15ca71be, 32'h2b73aef0, 32'h857d7781,
             32'h1f352c07, 32'h3b6108d7, 32'h2d9810a3, 32'h0914dff4};
    k128 = '{32'h2b7e1516, 32'h28aed2a6, 32'habf71588, 32'h09cf4f3c,
             32'h0, 32'h0, 32'h0, 32'h0};
    k192 = '{32'h8e73b0f7, 32'hda0e6452, 32'hc810f32b, 32'h809079e5,
             32'h62f8ead2, 32'h522c6b7b, 32'h0, 32'h0};
    test_reset();
    test_known_answer(2, 8, k256, 8, 32'h9ba35411, 12, 32'ha8b09c1a, 32'h706c631e);
    test_known_answer(0, 4, k128, 4, 32'ha0fafe17, 0, 32'h2b7e1516, 32'hb6630ca6);
    test_known_answer(1, 6, k192, 6, 32'hfe0c91f7, 0, 32'h8e73b0f7, 32'h01002202);
    test_backpressure(k256);
    test_random_keys();
    test_abort_restart(k256);
    test_reset_mid_run(k256);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
